// File: rtl/axi_rr_arbiter_pkg.sv
// axi_arb_pkg: shared FSM state type and sizing helpers for the round-robin arbiter
package axi_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    // Index width for n masters, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // All-ones error payload for a field of w bits (w up to 64).
    function automatic logic [63:0] err_data(input int w);
        return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/axi_if.sv
// axi: request/response link; M = {c, a, b} from master, S = {f, d, e} from slave
interface axi #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 32
);
    typedef struct packed {
        logic                  c;
        logic [ADDR_WIDTH-1:0] a;
        logic [ADDR_WIDTH-1:0] b;
    } m_t;

    typedef struct packed {
        logic                  f;
        logic [DATA_WIDTH-1:0] d;
        logic [DATA_WIDTH-1:0] e;
    } s_t;

    m_t M;
    s_t S;

    modport Master (output M, input S);
    modport Slave  (input M, output S);
endinterface

// File: rtl/axi_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first requester at or after rr_ptr
//   req       - request vector, one bit per master
//   rr_ptr    - highest-priority index this round
//   gnt_valid - any request present
//   gnt_idx   - chosen master
module rr_pick import axi_arb_pkg::*; #(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   rr_ptr,
    output logic                  gnt_valid,
    output logic [idx_w(N)-1:0]   gnt_idx
);
    localparam int IDX_W = idx_w(N);
    localparam logic [2*N-1:0] ONE = 1;

    logic [2*N-1:0] dbl;

    // Two copies of req with bits below rr_ptr masked off; the lowest set bit
    // of the doubled vector is the wrapped round-robin winner.
    always_comb begin
        dbl       = {req, req} & ~((ONE << rr_ptr) - ONE);
        gnt_valid = |req;
        gnt_idx   = '0;
        for (int j = 2*N-1; j >= 0; j--)
            if (dbl[j]) gnt_idx = IDX_W'(j % N);
    end
endmodule

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: round-robin share of one downstream slave among NUM_MASTERS masters
//   clk, rst    - clock, asynchronous active-high reset
//   up[]        - upstream masters (M in, S out)
//   down        - shared downstream slave (M out, S in)
//   grant_id    - currently or last granted master
//   busy        - FSM not in IDLE
//   timeout_err - one-cycle pulse alongside a watchdog error response
module axi_rr_arbiter import axi_arb_pkg::*; #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    axi.Slave                             up [NUM_MASTERS],
    axi.Master                            down,
    output logic [idx_w(NUM_MASTERS)-1:0] grant_id,
    output logic                          busy,
    output logic                          timeout_err
);
    localparam int IDX_W = idx_w(NUM_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(err_data(DATA_WIDTH));

    state_e                state, state_n;
    logic [IDX_W-1:0]      rr_ptr, gnt_idx;
    logic                  gnt_valid, done, err;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_MASTERS-1:0] req;
    logic [ADDR_WIDTH-1:0] req_a [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0] req_b [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] rsp_d, rsp_e;

    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_up
        assign req[i]   = up[i].M.c;
        assign req_a[i] = up[i].M.a;
        assign req_b[i] = up[i].M.b;
        // Non-granted masters keep their last d/e; only f is forced low.
        always_ff @(posedge clk or posedge rst)
            if (rst) up[i].S <= '0;
            else begin
                up[i].S.f <= done && grant_id == IDX_W'(i);
                if (done && grant_id == IDX_W'(i)) begin
                    up[i].S.d <= rsp_d;
                    up[i].S.e <= rsp_e;
                end
            end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    // A real response wins over the watchdog when both land in the same cycle.
    always_comb begin
        state_n = state;
        done    = 1'b0;
        err     = 1'b0;
        case (state)
            IDLE: state_n = gnt_valid ? BUSY : IDLE;
            BUSY: begin
                done    = down.S.f || cnt == CNT_W'(TIMEOUT);
                err     = !down.S.f && cnt == CNT_W'(TIMEOUT);
                state_n = done ? RESP : BUSY;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign rsp_d = err ? ERR_DATA : down.S.d;
    assign rsp_e = err ? ERR_DATA : down.S.e;
    assign busy  = state != IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            down.M      <= '0;
        end else
            case (state)
                IDLE: if (gnt_valid) begin
                    down.M   <= {1'b1, req_a[gnt_idx], req_b[gnt_idx]};
                    grant_id <= gnt_idx;
                end
                BUSY: if (done) begin
                    down.M.c    <= 1'b0;
                    timeout_err <= err;
                end else
                    cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
                RESP: begin
                    timeout_err <= 1'b0;
                    cnt         <= '0;
                    rr_ptr      <= (grant_id == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_id + 1'b1;
                end
                default: ;
            endcase
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter: directed scoreboard bench for axi_rr_arbiter
module tb_axi_rr_arbiter;
    localparam int N = 4, DW = 4, AW = 32, TO = 4;

    typedef struct {
        int         m;
        logic [3:0] d;
        logic [3:0] e;
        logic       err;
        int         gap;
    } rsp_t;

    typedef struct {
        string       tag;
        logic        busy;
        logic        c;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  gid;
        logic        terr;
        logic [3:0]  f;
        logic        qe;
    } snap_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic [N-1:0]  mc = '0;
    logic [AW-1:0] ma [N];
    logic [AW-1:0] mb [N];
    logic [N-1:0]  uf;
    logic [DW-1:0] ud [N];
    logic [DW-1:0] ue [N];
    int            sl_delay = -1, sl_cnt = 0;
    logic [DW-1:0] sl_d = '0, sl_e = '0;
    logic [1:0]    grant_id;
    logic          busy, timeout_err;
    rsp_t          exp_q [$];
    snap_t         snap_q [$];
    int            total = 0, bad = 0, cyc = 0, last_fc = 0;

    axi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) up [N] ();
    axi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) down ();

    axi_rr_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .up          (up),
        .down        (down),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    for (genvar g = 0; g < N; g++) begin : g_m
        assign up[g].M = {mc[g], ma[g], mb[g]};
        assign uf[g]   = up[g].S.f;
        assign ud[g]   = up[g].S.d;
        assign ue[g]   = up[g].S.e;
    end

    // Slave model: answers in the sl_delay-th BUSY cycle (0 = first), never if negative.
    assign down.S = {down.M.c && sl_cnt == sl_delay, sl_d, sl_e};
    always @(posedge clk or posedge rst) sl_cnt <= (rst || !down.M.c) ? 0 : sl_cnt + 1;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: applies queued snapshots and scores every upstream response.
    always @(negedge clk) begin
        cyc++;
        while (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            chk({s.tag, ".busy"}, busy, s.busy);
            chk({s.tag, ".down_c"}, down.M.c, s.c);
            chk({s.tag, ".down_a"}, down.M.a, s.a);
            chk({s.tag, ".down_b"}, down.M.b, s.b);
            chk({s.tag, ".grant_id"}, grant_id, s.gid);
            chk({s.tag, ".timeout_err"}, timeout_err, s.terr);
            chk({s.tag, ".up_f"}, uf, s.f);
            if (s.qe) chk({s.tag, ".pending"}, exp_q.size(), 0);
        end
        for (int i = 0; i < N; i++)
            if (uf[i]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_f: master %0d got a response, want none", i);
                end else begin
                    rsp_t r;
                    r = exp_q.pop_front();
                    chk("rsp.master", i, r.m);
                    chk("rsp.d", ud[i], r.d);
                    chk("rsp.e", ue[i], r.e);
                    chk("rsp.err", timeout_err, r.err);
                    if (r.gap != 0) chk("rsp.gap", cyc - last_fc, r.gap);
                end
                last_fc = cyc;
            end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap(input string tag, input logic bz, input logic c, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] gid, input logic te,
                        input logic [3:0] f, input logic qe = 1'b0);
        snap_t s;
        s = '{tag, bz, c, a, b, gid, te, f, qe};
        snap_q.push_back(s);
    endtask

    task automatic exp_rsp(input int m, input logic [3:0] d, input logic [3:0] e,
                           input logic err, input int gap = 0);
        rsp_t r;
        r = '{m, d, e, err, gap};
        exp_q.push_back(r);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        tick(2);
        snap("reset", 0, 0, 0, 0, 0, 0, 4'b0000);
        tick;
        rst = 1'b0;

        // single request from master 2, immediate answer
        mc[2] = 1; ma[2] = 32'h1000; mb[2] = 32'h2000;
        sl_delay = 0; sl_d = 4'h5; sl_e = 4'h9;
        exp_rsp(2, 4'h5, 4'h9, 0);
        snap("t1.idle", 0, 0, 0, 0, 0, 0, 4'b0000);
        tick; snap("t1.busy", 1, 1, 32'h1000, 32'h2000, 2, 0, 4'b0000);
        tick; snap("t1.resp", 1, 0, 32'h1000, 32'h2000, 2, 0, 4'b0100); mc[2] = 0;
        tick; snap("t1.after", 0, 0, 32'h1000, 32'h2000, 2, 0, 4'b0000);

        // rr_ptr now 3: master 3 beats master 0, then master 0 follows
        mc[0] = 1; ma[0] = 32'h0101; mb[0] = 32'h0102;
        mc[3] = 1; ma[3] = 32'h3333; mb[3] = 32'h3334;
        sl_d = 4'hC; sl_e = 4'hD;
        exp_rsp(3, 4'hC, 4'hD, 0);
        exp_rsp(0, 4'hC, 4'hD, 0, 3);
        tick; snap("t2.busy3", 1, 1, 32'h3333, 32'h3334, 3, 0, 4'b0000);
        tick; mc[3] = 0;
        tick;
        tick; snap("t2.busy0", 1, 1, 32'h0101, 32'h0102, 0, 0, 4'b0000);
        tick; mc[0] = 0;
        tick;

        // silent slave: error response 5 cycles after BUSY entry
        mc[0] = 1; ma[0] = 32'hA0; mb[0] = 32'hB0; sl_delay = -1;
        exp_rsp(0, 4'hF, 4'hF, 1);
        for (int k = 0; k < 5; k++) begin
            tick; snap("t3.wait", 1, 1, 32'hA0, 32'hB0, 0, 0, 4'b0000);
        end
        tick; snap("t3.err", 1, 0, 32'hA0, 32'hB0, 0, 1, 4'b0001); mc[0] = 0;
        tick; snap("t3.idle", 0, 0, 32'hA0, 32'hB0, 0, 0, 4'b0000);

        // answer lands on the very cycle the counter hits TIMEOUT
        mc[1] = 1; ma[1] = 32'h1111; mb[1] = 32'h1112;
        sl_delay = TO; sl_d = 4'h3; sl_e = 4'h6;
        exp_rsp(1, 4'h3, 4'h6, 0);
        tick(5); snap("t4.last", 1, 1, 32'h1111, 32'h1112, 1, 0, 4'b0000);
        tick; snap("t4.resp", 1, 0, 32'h1111, 32'h1112, 1, 0, 4'b0010); mc[1] = 0;
        tick;

        // master 3 busy, changes a mid-flight; master 1 requests meanwhile
        mc[3] = 1; ma[3] = 32'h3000; mb[3] = 32'h3100;
        sl_delay = 2; sl_d = 4'h7; sl_e = 4'h8;
        exp_rsp(3, 4'h7, 4'h8, 0);
        exp_rsp(1, 4'h7, 4'h8, 0, 5);
        tick; snap("t5.b1", 1, 1, 32'h3000, 32'h3100, 3, 0, 4'b0000);
        ma[3] = 32'hDEAD; mc[1] = 1; ma[1] = 32'h1100; mb[1] = 32'h1200;
        tick; snap("t5.b2", 1, 1, 32'h3000, 32'h3100, 3, 0, 4'b0000);
        tick;
        tick; snap("t5.resp", 1, 0, 32'h3000, 32'h3100, 3, 0, 4'b1000); mc[3] = 0;
        tick;
        tick; snap("t5.m1", 1, 1, 32'h1100, 32'h1200, 1, 0, 4'b0000);
        tick(2);
        tick; mc[1] = 0;
        tick;

        // reset during BUSY aborts silently; master 0 then wins over master 1
        mc[2] = 1; ma[2] = 32'h2222; mb[2] = 32'h2223; sl_delay = -1;
        tick; snap("t6.busy", 1, 1, 32'h2222, 32'h2223, 2, 0, 4'b0000);
        tick; rst = 1; snap("t6.rst", 0, 0, 0, 0, 0, 0, 4'b0000);
        tick;
        rst = 0; mc[2] = 0;
        mc[0] = 1; ma[0] = 32'h0A0A; mb[0] = 32'h0B0B;
        mc[1] = 1; ma[1] = 32'h1A1A; mb[1] = 32'h1B1B;
        sl_delay = 0; sl_d = 4'h1; sl_e = 4'h2;
        exp_rsp(0, 4'h1, 4'h2, 0);
        exp_rsp(1, 4'h1, 4'h2, 0, 3);
        tick; snap("t6.win0", 1, 1, 32'h0A0A, 32'h0B0B, 0, 0, 4'b0000);
        tick; mc[0] = 0;
        tick(2); snap("t6.next1", 1, 1, 32'h1A1A, 32'h1B1B, 1, 0, 4'b0000);
        tick; mc[1] = 0;
        tick;

        // fairness: all four requesting continuously from reset
        rst = 1;
        tick;
        rst = 0;
        for (int i = 0; i < N; i++) begin
            ma[i] = 32'h5000 + 32'(i);
            mb[i] = 32'h6000 + 32'(i);
        end
        mc = '1; sl_d = 4'hA; sl_e = 4'h5;
        exp_rsp(0, 4'hA, 4'h5, 0);
        exp_rsp(1, 4'hA, 4'h5, 0, 3);
        exp_rsp(2, 4'hA, 4'h5, 0, 3);
        exp_rsp(3, 4'hA, 4'h5, 0, 3);
        exp_rsp(0, 4'hA, 4'h5, 0, 3);
        tick(14);
        mc = '0;
        tick(3);
        snap("end", 0, 0, 32'h5000, 32'h6000, 0, 0, 4'b0000, 1'b1);
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_rr_arbiter.md
Name: axi_rr_arbiter

Overview:
- Round-robin arbiter that shares one axi slave between NUM_MASTERS axi masters.
- Only one transaction is outstanding at any time.
- A transaction is: the master holds M.c high with address fields a and b, and the slave answers with a single-cycle S.f pulse carrying d and e.
- The block sits between the axi Master-side initiators and the single shared axi Slave.
- It registers each request, forwards it downstream, and returns the response to the granted master.
- A timeout watchdog returns an error response if the slave does not answer.

Parameters:
- NUM_MASTERS, 4, number of upstream masters; legal range 2..16.
- DATA_WIDTH, 4, width of the S.d and S.e fields on all ports.
- ADDR_WIDTH, 32, width of the M.a and M.b fields on all ports.
- TIMEOUT, 255, maximum number of BUSY cycles to wait for S.f before aborting; legal range 1..65535.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- up  interface array [NUM_MASTERS]  axi.Slave  upstream masters; M is input, S is output.
- down  interface  axi.Master  shared downstream slave; M is output, S is input.
- grant_id  output  $clog2(NUM_MASTERS)  index of the currently or last granted master.
- busy  output  1  high whenever the FSM is not in IDLE.
- timeout_err  output  1  one-cycle pulse, coincident with the error response.

Behaviour:
- Reset (asynchronous): state=IDLE, rr_ptr=0, grant_id=0, busy=0, timeout_err=0, down.M.c=0, down.M.a=0, down.M.b=0, every up[i].S.f=0, every up[i].S.d=0, every up[i].S.e=0, wait counter=0.
- Reset asserted mid-transaction aborts the transaction silently. No response is returned to the master.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any up[i].M.c is high, pick the first requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
  - Latch that master's a and b into the down.M registers and set grant_id=i.
  - Go to BUSY.
  - If no request is present, stay in IDLE.
- BUSY:
  - down.M.c=1 and busy=1; down.M.a and down.M.b hold the latched values.
  - Changes on upstream a, b or c are ignored.
  - If down.S.f=1: capture down.S.d and down.S.e, then go to RESP.
  - Otherwise increment the wait counter. When the counter reaches TIMEOUT, load d='1 and e='1 (the ERR_DATA constant) and go to RESP with timeout_err armed.
  - down.S.f arriving in the same cycle the counter reaches TIMEOUT counts as a normal response: real data is returned and timeout_err stays 0.
- RESP:
  - down.M.c=0.
  - up[grant_id].S.f=1 for exactly one cycle, with the captured d and e.
  - timeout_err=1 if armed.
  - Set rr_ptr=(grant_id+1) mod NUM_MASTERS, clear the counter, go to IDLE.
- up[i].S.d, S.e and S.f are driven only for i==grant_id. All other masters see f=0, and their d and e hold their last values.
- The master protocol requirement, which the bench must model: the master deasserts M.c in the cycle after it sees S.f, or keeps it high to issue a new request.
- In IDLE the arbiter samples c as-is. A master holding c high after RESP is treated as a new request and gets no priority bonus, because rr_ptr has already advanced past it.
- Minimum latency is 3 cycles from the request edge to up.S.f, when the slave responds in its first BUSY cycle:
  - cycle 0: IDLE samples c;
  - cycle 1: BUSY, slave sees c, f=1;
  - cycle 2: RESP, up f=1.
- Back-to-back throughput is one transaction every 3 cycles minimum, since IDLE always takes one cycle.
- down.S.f while in IDLE or RESP is ignored. It is a protocol error and is not forwarded.
- The wait counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Fairness: with all requesters continuously active, each master is granted exactly once per NUM_MASTERS transactions.

Decomposition:
- Package axi_arb_pkg holds:
  - the state_e enum (IDLE, BUSY, RESP);
  - the ERR_DATA all-ones constant function of DATA_WIDTH;
  - a clog2-based IDX_W helper.
- One sub-module, rr_pick:
  - combinational;
  - inputs: req vector [NUM_MASTERS] and rr_ptr;
  - outputs: gnt_valid and gnt_idx;
  - implemented as a double-width mask-and-priority-encode.
- The FSM, latches and counter live in axi_rr_arbiter.

Test Plan:
- Single request: up[2].M.c=1, a=0x1000, b=0x2000, slave answers f=1 with d=5, e=9 in the first BUSY cycle -> down.M.a=0x1000 and down.M.b=0x2000 in cycle 1; up[2].S.f=1 with d=5, e=9 in cycle 2; grant_id=2; rr_ptr=3.
- All four masters requesting continuously from reset, slave answers immediately -> grant order 0,1,2,3,0; every up f pulse is exactly one cycle; grants are spaced 3 cycles apart.
- Slave never answers, TIMEOUT=4 -> up[0].S.f=1 with d=0xF, e=0xF, and timeout_err=1 in the same cycle, 5 cycles after entering BUSY; the FSM then returns to IDLE.
- down.S.f arrives on the exact cycle the counter reaches TIMEOUT, d=3 -> real data 3 is returned and timeout_err=0.
- Request from master 1 while master 3 is in BUSY, with master 3 changing a mid-transaction -> down.M.a is unchanged; master 1 is granted on the next IDLE.
- rst asserted during BUSY -> down.M.c=0, busy=0 and grant_id=0 immediately (asynchronously); no f pulse to any master; after release, master 0 wins a simultaneous 0/1 request.
